clint_rtc_gen: RTL
==================

// Module: clint_rtc_gen
// PURPOSE
// - Generates the real-time-clock square wave consumed by the CLINT rtc input, derived from the system clock.
// - Uses a fractional phase accumulator. Output frequency is f_clk * incr / 2^AccWidth.
// - Sits next to the CLINT in the SoC control domain and replaces the external 32.768 kHz pin where none exists.
// - The increment is reprogrammed through a valid/ready config port. Updates take effect glitch-free at a period boundary.
// PARAMETERS
// - AccWidth    32    phase-accumulator width in bits, >= 4
// - DefaultIncr 0     increment loaded at reset; 0 keeps the RTC frozen until configured
// PORTS
// - clk_i        in   1         system clock; single clock domain
// - rst_ni       in   1         asynchronous reset, active low
// - en_i         in   1         run enable; when low the accumulator and rtc_o hold their values
// - cfg_valid_i  in   1         new increment offered
// - cfg_ready_o  out  1         new increment can be accepted
// - cfg_incr_i   in   AccWidth  new increment value
// - rtc_o        out  1         RTC square wave, driven from a flop; connects to the CLINT rtc input
// - tick_o       out  1         one-cycle pulse, coincident with each 0->1 transition of rtc_o
// - pending_o    out  1         an accepted increment is waiting for the next period boundary
// BEHAVIOUR
// - Reset values: acc_q=0, incr_q=sat(DefaultIncr), rtc_o=0, tick_o=0, pending_o=0, cfg_ready_o=1.
// - sat(x) = min(x, 2^(AccWidth-1)), applied on every load, so that each half-period lasts >= 1 clk.
// - Accumulator: each cycle with en_i=1, {carry, acc_d} = acc_q + incr_q. The sum is modulo 2^AccWidth.
// - With en_i=0, acc_d = acc_q and carry = 0.
// - Outputs: rtc_o = acc_q[AccWidth-1], a direct flop output.
// - tick_o is registered as ~acc_q[MSB] & acc_d[MSB], so it is high in the same cycle rtc_o first reads 1.
// - Period boundary: any cycle with carry=1. This is the falling edge of rtc_o.
// - Config FSM states: IDLE (cfg_ready_o=1, pending_o=0) and PEND (cfg_ready_o=0, pending_o=1).
// - IDLE, handshake (valid & ready), en_i=0: incr_q <= sat(cfg_incr_i) next cycle; stay in IDLE.
// - IDLE, handshake, en_i=1: pend_q <= sat(cfg_incr_i); go to PEND.
// - PEND, carry=1: incr_q <= pend_q; go to IDLE. cfg_ready_o returns to 1 the following cycle.
// - PEND, en_i falls to 0: incr_q <= pend_q next cycle; go to IDLE. A stopped clock has no glitch to avoid.
// - Handshake in the same cycle as a carry: the carry does not apply the new value. It waits for the next boundary.
// - The accumulator residue is never cleared on an increment change, so phase stays continuous.
// - incr_q = 0: no carries ever occur. rtc_o holds its current level.
// -   If a PEND entry is waiting with en_i=1, it never applies until en_i drops. This is documented and intended.
// - cfg_valid_i may be withdrawn while cfg_ready_o=0. No stability requirement exists on unaccepted data.
// - Reset mid-operation returns every flop to its reset value asynchronously. Pending data is discarded.
// CONFIGURATION
// - CLINT_RTC_GEN_TICKCNT_EN defined: adds output tick_cnt_o [63:0].
// -   tick_cnt_o is reset to 0 and increments by 1 (wrapping at 2^64) in each cycle where tick_o=1.
// -   It mirrors the CLINT mtime increment count, for cross-checking.
// - Macro undefined: the port and its counter are absent. All other behaviour is identical.
// TESTING (AccWidth=8 unless stated)
// 1. Reset with DefaultIncr=0, en_i=1 for 20 cycles -> rtc_o=0, tick_o=0, cfg_ready_o=1 throughout.
// 2. With en_i=0, write incr=64, then set en_i=1 -> acc_q runs 0,64,128,192,0,...
// -    rtc_o follows 0,0,1,1 repeating; tick_o pulses every 4 cycles, aligned to each rtc_o rise.
// 3. While running at incr=64, write incr=32 mid-period -> pending_o=1, cfg_ready_o=0 until the next rtc_o fall.
// -    Then the rtc_o period becomes 8 cycles, with no high or low phase shorter than 2 cycles.
// 4. Write incr=200 -> saturates to 128; rtc_o toggles every cycle (clk/2).
// -    Handshake in the same cycle as a carry -> the new value applies one boundary later.
// 5. Assert rst_ni low while in PEND -> next cycle after release: pending_o=0, rtc_o=0, incr_q=DefaultIncr.
// -    Drop en_i in PEND -> incr_q updates next cycle and rtc_o holds its level.
// 6. With CLINT_RTC_GEN_TICKCNT_EN, incr=64 for 400 cycles -> tick_cnt_o=100 and equals the number of tick_o pulses.
// -    Without the macro the build is clean and tick_cnt_o is absent.

Source files
------------

// File: rtl/clint_rtc_gen.sv
// clint_rtc_gen: phase-accumulator RTC square wave for the CLINT with boundary-aligned increment reload; optional tick counter under CLINT_RTC_GEN_TICKCNT_EN
module clint_rtc_gen #(
  parameter int unsigned         AccWidth    = 32,
  parameter logic [AccWidth-1:0] DefaultIncr = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [AccWidth-1:0] cfg_incr_i,
  output logic                rtc_o,
  output logic                tick_o,
  output logic                pending_o
`ifdef CLINT_RTC_GEN_TICKCNT_EN
  ,
  output logic [63:0]         tick_cnt_o
`endif
);
  localparam logic [AccWidth-1:0] Half = {1'b1, {(AccWidth-1){1'b0}}};
  typedef enum logic {IDLE, PEND} state_e;
  function automatic logic [AccWidth-1:0] sat(input logic [AccWidth-1:0] x);
    return x > Half ? Half : x;
  endfunction
  state_e              state_q, state_d;
  logic [AccWidth-1:0] acc_q, acc_d, incr_q, incr_d, pend_q, pend_d;
  logic [AccWidth:0]   sum;
  logic                carry, hs;
  assign cfg_ready_o = state_q == IDLE;
  assign pending_o   = state_q == PEND;
  assign rtc_o       = acc_q[AccWidth-1];
  assign hs          = cfg_valid_i & cfg_ready_o;
  // accumulator step; a stopped accumulator never produces a period boundary
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, incr_q};
    carry = en_i & sum[AccWidth];
    acc_d = en_i ? sum[AccWidth-1:0] : acc_q;
  end
  // increment reload: direct while stopped, otherwise deferred to the next rtc_o fall
  always_comb begin
    state_d = state_q;
    incr_d  = incr_q;
    pend_d  = pend_q;
    if (state_q == IDLE) begin
      if (hs && en_i) begin
        pend_d  = sat(cfg_incr_i);
        state_d = PEND;
      end else if (hs) begin
        incr_d = sat(cfg_incr_i);
      end
    end else if (carry || !en_i) begin
      incr_d  = pend_q;
      state_d = IDLE;
    end
  end
  // state registers; the residue in acc_q is kept across reloads for phase continuity
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      incr_q  <= sat(DefaultIncr);
      pend_q  <= '0;
      tick_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      incr_q  <= incr_d;
      pend_q  <= pend_d;
      tick_o  <= ~acc_q[AccWidth-1] & acc_d[AccWidth-1];
    end
  end
`ifdef CLINT_RTC_GEN_TICKCNT_EN
  // count rtc rising edges to cross-check the CLINT mtime increments
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tick_cnt_o <= '0;
    else         tick_cnt_o <= tick_cnt_o + {63'd0, tick_o};
  end
`endif
endmodule
